// File: rtl/input_debouncer.sv
// input_debouncer
// Turns a raw, bouncy, asynchronous level (button, jumper, external flag)
// into a clean synchronous level plus one-cycle rise/fall strobes.
// A new level is accepted only after 2^BITS consecutive synchronized
// samples that disagree with the current level. Any agreeing sample in
// between restarts the window from scratch.
// Optional build macro DEBOUNCE_REPEAT_EN adds an auto-repeat strobe (rpt)
// while the level is held high. Without it, rpt is tied low.
// The port list is the same in both builds.
module input_debouncer #(
  parameter int BITS        = 20,
  parameter int SYNC_STAGES = 2,
  parameter int REPEAT_BITS = 22
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rpt
);

  // Reject parameter values the structure below cannot support.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("input_debouncer: SYNC_STAGES must be 2..4");
  end
  if (BITS < 1) begin : g_bad_bits
    $error("input_debouncer: BITS must be at least 1");
  end
  if (REPEAT_BITS < 1) begin : g_bad_repeat_bits
    $error("input_debouncer: REPEAT_BITS must be at least 1");
  end

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t                 state_q, state_d;
  logic [BITS-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Synchronizer chain: nothing else looks at the raw input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // FSM state, window counter, debounced level and strobe registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next state: the first mismatching sample opens the window. A matching
  // sample closes it without an event. The sample taken at an all-ones
  // count commits the new level, so the counter never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE: begin
        if (s != level_q) begin
          state_d = PENDING;
          cnt_d   = BITS'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      PENDING: begin
        if (s == level_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (&cnt_q) begin
          state_d = STABLE;
          cnt_d   = '0;
          level_d = s;
          rise_d  = s;
          fall_d  = ~s;
        end else begin
          cnt_d   = cnt_q + BITS'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
  logic [REPEAT_BITS-1:0] rcnt_q, rcnt_d;
  logic                   rpt_q, rpt_d;

  // Repeat counter: held at zero while the level is low, so it starts at
  // zero on the rise edge. It then free-runs while the level is high. The
  // wrap from all-ones fires rpt, except on the edge that commits a fall.
  always_comb begin
    rcnt_d = '0;
    rpt_d  = 1'b0;
    if (level_q) begin
      rcnt_d = rcnt_q + REPEAT_BITS'(1);
      rpt_d  = (&rcnt_q) & ~fall_d;
    end
  end

  // Repeat counter and strobe registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt_q <= '0;
      rpt_q  <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      rpt_q  <= rpt_d;
    end
  end

  assign rpt = rpt_q;
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with BITS=2, SYNC_STAGES=2,
// REPEAT_BITS=3. Expected outputs are packed as {level, rise, fall, rpt}.
module tb_input_debouncer;

`ifdef DEBOUNCE_REPEAT_EN
  localparam logic REP = 1'b1;
`else
  localparam logic REP = 1'b0;
`endif

  logic clk;
  logic reset;
  logic in;
  logic level, rise, fall, rpt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         rst;
    logic       in;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];

  input_debouncer #(
    .BITS(2),
    .SYNC_STAGES(2),
    .REPEAT_BITS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in(in),
    .level(level),
    .rise(rise),
    .fall(fall),
    .rpt(rpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] outs();
    return {level, rise, fall, rpt};
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  // Present a value before the next rising edge, then look just after it.
  task automatic step(input logic v);
    @(negedge clk);
    in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add(input bit r, input logic i, input logic [3:0] e, input int n);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.rst = (k == 0) ? r : 1'b0;
      v.in  = i;
      v.exp = e;
      tbl.push_back(v);
    end
  endtask

  initial begin
    logic [3:0] e;

    // Basic rise then fall, full latency each way.
    add(1, 1'b1, 4'b0000, 1);
    add(0, 1'b1, 4'b0000, 4);
    add(0, 1'b1, 4'b1100, 1);
    add(0, 1'b1, 4'b1000, 2);
    add(0, 1'b0, 4'b1000, 5);
    add(0, 1'b0, 4'b0010, 1);
    add(0, 1'b0, 4'b0000, 2);
    // A 3-cycle pulse is too short to register.
    add(1, 1'b1, 4'b0000, 3);
    add(0, 1'b0, 4'b0000, 5);
    // A 4-cycle pulse is just long enough.
    add(1, 1'b1, 4'b0000, 4);
    add(0, 1'b0, 4'b0000, 1);
    add(0, 1'b0, 4'b1100, 1);
    add(0, 1'b0, 4'b1000, 3);
    add(0, 1'b0, 4'b0010, 1);
    add(0, 1'b0, 4'b0000, 2);
    // Bouncing release: 1,0,1,0,0,1 then steady 0 gives one fall.
    add(1, 1'b1, 4'b0000, 5);
    add(0, 1'b1, 4'b1100, 1);
    add(0, 1'b1, 4'b1000, 3);
    add(0, 1'b0, 4'b1000, 1);
    add(0, 1'b1, 4'b1000, 1);
    add(0, 1'b0, 4'b1000, 2);
    add(0, 1'b1, {3'b100, REP}, 1);
    add(0, 1'b0, 4'b1000, 5);
    add(0, 1'b0, 4'b0010, 1);
    add(0, 1'b0, 4'b0000, 2);

    // Reset state, checked while reset is still asserted.
    reset = 1'b0;
    in    = 1'b0;
    #2 reset = 1'b1;
    #2 chk("reset_state", outs(), 4'b0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Quiet input after reset: nothing moves.
    for (int k = 1; k <= 20; k++) begin
      step(1'b0);
      chk($sformatf("idle_k%0d", k), outs(), 4'b0000);
    end

    // Table-driven vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].in);
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Long hold: repeat strobes 8, 16, 24, 32 cycles after rise.
    // None is allowed on the edge that commits the fall.
    do_reset();
    for (int k = 1; k <= 60; k++) begin
      step(k <= 40);
      e[3] = (k >= 6 && k <= 45);
      e[2] = (k == 6);
      e[1] = (k == 46);
      e[0] = REP && (k == 14 || k == 22 || k == 30 || k == 38);
      chk($sformatf("hold_k%0d", k), outs(), e);
    end

    // Reset while the window is open (cnt = 2), with in kept high.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      step(1'b1);
      chk($sformatf("pend_k%0d", k), outs(), 4'b0000);
    end
    #2 reset = 1'b1;
    #1 chk("rst_pending", outs(), 4'b0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int p = 1; p <= 7; p++) begin
      @(posedge clk);
      #1;
      e = (p == 6) ? 4'b1100 : (p == 7) ? 4'b1000 : 4'b0000;
      chk($sformatf("post_rst_p%0d", p), outs(), e);
    end
    // Reset with the level high must clear it without waiting for a clock.
    #2 reset = 1'b1;
    #1 chk("rst_async_level", outs(), 4'b0000);
    @(negedge clk);
    in = 1'b0;
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b0);
      chk($sformatf("tail_k%0d", k), outs(), 4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Conditions a raw, asynchronous, bouncy level input such as a button, jumper or external flag into a clean synchronous level with single-cycle edge strobes. It is the receive-side counterpart of the pulse stretcher: the stretcher widens short internal events for slow observers, and this block rejects short external events and reduces long ones to one-clock strobes for the fabric. It sits between the board pins and control logic that wants exactly one event per press or release.

## Interface
- BITS, 20: debounce window exponent; a new level must hold for 2^BITS consecutive synchronized samples.
- SYNC_STAGES, 2: flip-flop synchronizer depth; legal values are 2 to 4.
- REPEAT_BITS, 22: auto-repeat period exponent; used only with DEBOUNCE_REPEAT_EN.
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- in  input  1  raw asynchronous level; may bounce.
- level  output  1  debounced level; registered.
- rise  output  1  one-cycle strobe when level goes 0→1.
- fall  output  1  one-cycle strobe when level goes 1→0.
- rpt  output  1  one-cycle auto-repeat strobe while level is held high; constant 0 when the feature is compiled out.

## Operation
- Synchronizer: `in` passes through SYNC_STAGES flops. The last flop is `s`. No other logic touches `in`.
- The state machine has two states: STABLE and PENDING. It also holds a BITS-wide counter `cnt` and the `level` register.
- STABLE, when s == level: hold the state with cnt = 0.
- STABLE, when s != level: go to PENDING with cnt ← 1.
- PENDING, when s == level (a bounce): go back to STABLE with cnt ← 0. No strobe is issued.
- PENDING, when s != level and cnt is all-ones: commit.
  - level ← s.
  - Pulse rise if s = 1, or fall if s = 0, for one cycle.
  - cnt ← 0 and go to STABLE.
- PENDING, when s != level and cnt is not all-ones: cnt ← cnt + 1.
- cnt never wraps. Commit takes priority at all-ones.
- A commit therefore needs exactly 2^BITS consecutive mismatching samples of `s`: the STABLE sample plus the samples at cnt = 1 … 2^BITS−1.
- rise and fall are never high in the same cycle. Each is high for exactly one cycle per commit.
- Reset values: level = 0, rise = 0, fall = 0, rpt = 0, all synchronizer flops = 0, cnt = 0, state = STABLE.
- Reset mid-operation aborts any PENDING state without a strobe. If `in` is high after reset is released, a rise follows after the full latency.

## Timing
- Latency: SYNC_STAGES + 2^BITS clock edges. It is measured from the first edge that samples the new `in` value to the edge that updates level and raises the strobe.
- rise/fall are asserted in the same cycle that level first shows the new value.
- Minimum accepted pulse: `in` stable for 2^BITS cycles, with setup met at each edge.
  - A pulse of 2^BITS − 1 cycles produces no event.
- Bounces restart the window fully. There is no accumulation across bounces.
- Maximum strobe rate: one strobe per 2^BITS cycles.

## Configuration
- Macro: DEBOUNCE_REPEAT_EN.
- When the macro is defined:
  - A REPEAT_BITS-wide counter `rcnt` is cleared on every rise and whenever level = 0.
  - While level = 1 it increments every cycle.
  - When it wraps from all-ones to 0, rpt pulses for one cycle.
  - The first rpt therefore comes 2^REPEAT_BITS cycles after rise, and rpt repeats every 2^REPEAT_BITS cycles while level is held.
  - rpt never coincides with rise.
  - rcnt resets to 0.
- When the macro is not defined: rcnt is absent and rpt is tied to 0. The port list is identical in both builds.

## Test plan
All scenarios use BITS=2, SYNC_STAGES=2, REPEAT_BITS=3.

- Reset release with in = 0 held for 20 cycles → level, rise, fall and rpt stay 0 throughout.
- in 0→1 sampled at edge E1 and held → level = 1 and rise = 1 at E6, and only at E6. No fall.
- in pulses high for exactly 3 cycles → no rise and level stays 0. A pulse of 4 cycles → rise once, level = 1. fall follows 6 edges after in returns to 0.
- With level = 1, in toggles 1,0,1,0,0,1 (bounce) then stays 0 → exactly one fall.
  - The fall occurs 6 edges after the final 1→0 sample.
  - No rise occurs during the bounce.
- With DEBOUNCE_REPEAT_EN defined and in held high → rpt pulses 8, 16 and 24 cycles after rise, and never after fall.
  - Without the macro, rpt = 0 throughout.
- reset asserted while in PENDING (in high, cnt = 2) → all outputs 0 immediately.
  - After release with in still high, rise arrives 6 edges after the first post-reset sampling edge.
